// File: rtl/cntr_rr_sched.sv
// Round-robin scheduler sharing one loadable up-counter among NREQ requesters.
// Each grant loads ~len into the counter and ends when the counter reaches all-ones or the owner drops its request.
module cntr_rr_sched #(
    parameter int NREQ = 4,
    parameter int W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] len,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic              busy,
    output logic              cntr_ld,
    output logic [W-1:0]      cntr_d,
    input  logic [W-1:0]      cntr_q
);

    localparam int PW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, FIN} state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic              busy_q, busy_d;
    logic              cntr_ld_q, cntr_ld_d;
    logic [W-1:0]      cntr_d_q, cntr_d_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     owner_q, owner_d;

    logic [PW-1:0]     cand [NREQ];
    logic [NREQ-1:0]   cand_req;
    logic [PW-1:0]     win_idx;
    logic [PW-1:0]     owner_next;

    // Candidate k is requester (ptr + k) mod NREQ, so position 0 has the highest priority.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_cand
            logic [PW:0] sum_w;
            assign sum_w        = {1'b0, ptr_q} + (PW+1)'(gi);
            assign cand[gi]     = (sum_w >= (PW+1)'(NREQ)) ? PW'(sum_w - (PW+1)'(NREQ))
                                                          : sum_w[PW-1:0];
            assign cand_req[gi] = req[cand[gi]];
        end
    endgenerate

    always_comb begin
        win_idx = ptr_q;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (cand_req[k]) begin
                win_idx = cand[k];
            end
        end
    end

    assign owner_next = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        done_d    = '0;
        cntr_ld_d = 1'b0;
        cntr_d_d  = cntr_d_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    owner_d   = win_idx;
                    cntr_d_d  = ~len[win_idx*W +: W];
                    gnt_d     = NREQ'(1) << win_idx;
                    cntr_ld_d = 1'b1;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                state_d = RUN;
            end
            RUN: begin
                // Terminal count is checked first so it wins over a same-cycle request drop.
                if (cntr_q == {W{1'b1}}) begin
                    gnt_d   = '0;
                    done_d  = NREQ'(1) << owner_q;
                    state_d = FIN;
                end else if (!req[owner_q]) begin
                    gnt_d   = '0;
                    state_d = FIN;
                end
            end
            FIN: begin
                gnt_d   = '0;
                ptr_d   = owner_next;
                state_d = IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            done_q    <= '0;
            busy_q    <= 1'b0;
            cntr_ld_q <= 1'b0;
            cntr_d_q  <= '0;
            ptr_q     <= '0;
            owner_q   <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            cntr_ld_q <= cntr_ld_d;
            cntr_d_q  <= cntr_d_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
        end
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign busy    = busy_q;
    assign cntr_ld = cntr_ld_q;
    assign cntr_d  = cntr_d_q;

endmodule
